ped_request_unit: RTL and testbench
===================================

Name: ped_request_unit

Overview:
Pedestrian-side front end of the crossing handshake. Synchronizes and debounces the raw push-button, then raises a level-held ped_button request to traffic_light_controller. It releases the request when the controller answers with ped_walk, shows a walk countdown, and enforces a lockout so one press yields exactly one crossing cycle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high samples required to accept a press (>=1)
WALK_CYCLES, 8, value loaded into walk_count at grant; display countdown start
LOCKOUT_CYCLES, 6, cycles after ped_walk falls during which presses are ignored (>=1)
CNT_W, 4, width of internal debounce/lockout counters and walk_count; must hold max of the three above

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
btn_raw  input  1  asynchronous, bouncy pedestrian button
ped_walk  input  1  grant/walk indication from traffic_light_controller
ped_button  output  1  registered request to controller, level-held until grant
wait_lamp  output  1  registered "WAIT" indicator, high while request pending
walk_count  output  CNT_W  registered walk countdown for display
req_total  output  8  registered count of granted requests, wraps 255->0

Behaviour:
- Reset (sampled on clk edge): state=IDLE; sync flops, counters, ped_button, wait_lamp, walk_count, req_total all 0. Reset mid-operation aborts any request/lockout immediately; no lockout is applied after reset.
- Synchronizer: btn_raw -> two flops -> btn_sync (2-cycle latency). Only btn_sync is used by the FSM.
- FSM states: IDLE, DEBOUNCE, REQUEST, WALK, LOCKOUT.
- IDLE: btn_sync=1 -> DEBOUNCE, deb_cnt=1. ped_walk ignored.
- DEBOUNCE: btn_sync=0 -> IDLE, deb_cnt=0. btn_sync=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> REQUEST. Otherwise deb_cnt++. If DEBOUNCE_CYCLES=1, IDLE goes directly to REQUEST. ped_walk ignored.
- Net latency: a btn_raw held high from edge N gives ped_button=1 after edge N+DEBOUNCE_CYCLES+1 (default: 5 edges).
- REQUEST: ped_button=1, wait_lamp=1. Further button activity is ignored. ped_walk=1 sampled -> WALK. On this transition walk_count<=WALK_CYCLES and req_total<=req_total+1 (mod 256). The request is never withdrawn except by reset.
- WALK: ped_button=0, wait_lamp=0. walk_count decrements by 1 each cycle while ped_walk=1 and walk_count>0, saturating at 0. ped_walk=0 -> LOCKOUT, walk_count<=0, lock_cnt<=0.
- LOCKOUT: lock_cnt++ each cycle, saturating at LOCKOUT_CYCLES. Exit to IDLE only when lock_cnt==LOCKOUT_CYCLES and btn_sync=0, so the button must be released before re-arming. A button held through lockout therefore stays in LOCKOUT until released.
- ped_walk already high when REQUEST is entered: WALK is taken on the next edge; at least one cycle of ped_button=1 is guaranteed.
- ped_walk pulse in IDLE/DEBOUNCE/LOCKOUT: no effect on any output.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, state IDLE; btn_raw=0 for 20 cycles -> outputs stay 0.
2. btn_raw high at edge N, held; ped_walk=0 -> ped_button and wait_lamp go 1 after edge N+5 and stay 1 for 30 cycles.
3. Bounce: btn_raw high 2 cycles, low 1, high 2, then low -> ped_button never asserts, req_total=0.
4. Full cycle: press accepted, ped_walk=1 three cycles later for 12 cycles -> ped_button falls the edge after grant is sampled; walk_count reads 8,7,...,0 then holds 0; req_total=1; after ped_walk falls, walk_count=0. A press 3 cycles later is ignored; a press released then re-pressed after 6+ lockout cycles yields a second request.
5. Held button: btn_raw kept high across grant and lockout -> no second request until btn_raw goes low for at least one synchronized sample and is pressed again.
6. Reset asserted while in REQUEST -> next edge: ped_button=0, wait_lamp=0, req_total unchanged from reset value 0. Wrap: 256 full cycles -> req_total returns to 0.

Source files
------------

// File: rtl/ped_request_unit.sv
// Pedestrian request front end for the crossing handshake.
// Synchronizes and debounces the raw button and holds a request to the
// traffic light controller until it grants ped_walk. It then shows a walk
// countdown and enforces a lockout, so one press produces one crossing cycle.
//
// Handshake: ped_button is a level-held request. It rises when a debounced
// press is accepted and stays high until the edge that samples ped_walk=1,
// and it falls on that same edge. ped_walk is sampled only in REQUEST and
// WALK; pulses seen in any other state have no effect.
//
// Timing: a btn_raw held high from edge N gives ped_button=1 after edge
// N+DEBOUNCE_CYCLES+1. The FSM state is held in the enum register "state".
module ped_request_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int LOCKOUT_CYCLES  = 6,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_walk,
    output logic             ped_button,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] walk_count,
    output logic [7:0]       req_total
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        REQUEST  = 3'd2,
        WALK     = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCKOUT_CYCLES);

    state_t           state;
    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] lock_cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Request FSM with registered outputs, counters and grant tally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            lock_cnt   <= '0;
            ped_button <= 1'b0;
            wait_lamp  <= 1'b0;
            walk_count <= '0;
            req_total  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        // With a one-sample debounce the first high sample is enough.
                        if (DEBOUNCE_CYCLES == 1) begin
                            state      <= REQUEST;
                            deb_cnt    <= '0;
                            ped_button <= 1'b1;
                            wait_lamp  <= 1'b1;
                        end else begin
                            state   <= DEBOUNCE;
                            deb_cnt <= CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!btn_sync) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state      <= REQUEST;
                        deb_cnt    <= '0;
                        ped_button <= 1'b1;
                        wait_lamp  <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_W'(1);
                    end
                end
                REQUEST: begin
                    // The request is only cleared by a grant or by reset.
                    if (ped_walk) begin
                        state      <= WALK;
                        ped_button <= 1'b0;
                        wait_lamp  <= 1'b0;
                        walk_count <= WALK_LOAD;
                        req_total  <= req_total + 8'd1;
                    end
                end
                WALK: begin
                    if (!ped_walk) begin
                        state      <= LOCKOUT;
                        walk_count <= '0;
                        lock_cnt   <= '0;
                    end else if (walk_count != '0) begin
                        walk_count <= walk_count - CNT_W'(1);
                    end
                end
                LOCKOUT: begin
                    // Re-arm only after the lockout has expired and the button is released.
                    if (lock_cnt == LOCK_MAX && !btn_sync) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (lock_cnt != LOCK_MAX) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge after each rising edge.
module tb_ped_request_unit;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       ped_walk;
    logic       ped_button;
    logic       wait_lamp;
    logic [3:0] walk_count;
    logic [7:0] req_total;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    ped_request_unit #(
        .DEBOUNCE_CYCLES(4),
        .WALK_CYCLES(8),
        .LOCKOUT_CYCLES(6),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .ped_walk(ped_walk),
        .ped_button(ped_button),
        .wait_lamp(wait_lamp),
        .walk_count(walk_count),
        .req_total(req_total)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press, a one-cycle grant, then enough idle cycles to clear lockout.
    task automatic full_cycle();
        btn_raw = 1'b1;
        step(6);
        btn_raw  = 1'b0;
        ped_walk = 1'b1;
        step(1);
        ped_walk = 1'b0;
        step(1);
        step(10);
    endtask

    initial begin
        reset    = 1'b1;
        btn_raw  = 1'b0;
        ped_walk = 1'b0;

        // 1. Reset for two cycles, then idle.
        step(2);
        chk("rst_ped_button", {7'd0, ped_button}, 8'd0);
        chk("rst_wait_lamp", {7'd0, wait_lamp}, 8'd0);
        chk("rst_walk_count", {4'd0, walk_count}, 8'd0);
        chk("rst_req_total", req_total, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_ped_button", {7'd0, ped_button}, 8'd0);
        end
        chk("idle_wait_lamp", {7'd0, wait_lamp}, 8'd0);

        // 2. Held press: request appears after edge N+5 and is held.
        btn_raw = 1'b1;
        step(5);
        chk("press_lat_early", {7'd0, ped_button}, 8'd0);
        step(1);
        chk("press_ped_button", {7'd0, ped_button}, 8'd1);
        chk("press_wait_lamp", {7'd0, wait_lamp}, 8'd1);
        for (int i = 0; i < 30; i++) begin
            step(1);
            chk("press_hold", {7'd0, ped_button}, 8'd1);
        end

        // 6a. Reset while in REQUEST aborts the request.
        reset   = 1'b1;
        btn_raw = 1'b0;
        step(1);
        chk("rstreq_ped_button", {7'd0, ped_button}, 8'd0);
        chk("rstreq_wait_lamp", {7'd0, wait_lamp}, 8'd0);
        chk("rstreq_req_total", req_total, 8'd0);
        reset = 1'b0;
        step(3);

        // 3. Bounce: 2 high, 1 low, 2 high, low.
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        step(1);
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("bounce_ped_button", {7'd0, ped_button}, 8'd0);
        end
        chk("bounce_req_total", req_total, 8'd0);

        // 4. Full cycle with a 12-cycle grant.
        btn_raw = 1'b1;
        step(6);
        chk("fc_request", {7'd0, ped_button}, 8'd1);
        btn_raw = 1'b0;
        step(3);
        chk("fc_wait_before_grant", {7'd0, wait_lamp}, 8'd1);
        exp_q.push_back(8'd8);
        for (int v = 7; v >= 0; v--) exp_q.push_back(8'(v));
        for (int i = 0; i < 3; i++) exp_q.push_back(8'd0);
        ped_walk = 1'b1;
        step(1);
        chk("fc_grant_ped_button", {7'd0, ped_button}, 8'd0);
        chk("fc_grant_wait_lamp", {7'd0, wait_lamp}, 8'd0);
        chk("fc_req_total", req_total, 8'd1);
        chk("fc_walk_count", {4'd0, walk_count}, exp_q.pop_front());
        for (int i = 0; i < 11; i++) begin
            step(1);
            chk("fc_walk_count", {4'd0, walk_count}, exp_q.pop_front());
        end
        ped_walk = 1'b0;
        step(1);
        chk("fc_lock_walk_count", {4'd0, walk_count}, 8'd0);
        chk("fc_lock_req_total", req_total, 8'd1);
        // Press three cycles into lockout, released before lockout expires.
        step(2);
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("lock_ignore", {7'd0, ped_button}, 8'd0);
        end
        chk("lock_ignore_total", req_total, 8'd1);
        // Fresh press after lockout yields a second request.
        btn_raw = 1'b1;
        step(6);
        chk("second_request", {7'd0, ped_button}, 8'd1);
        btn_raw  = 1'b0;
        ped_walk = 1'b1;
        step(1);
        chk("second_req_total", req_total, 8'd2);
        chk("second_walk_count", {4'd0, walk_count}, 8'd8);
        ped_walk = 1'b0;
        step(1);
        chk("second_lock_walk", {4'd0, walk_count}, 8'd0);
        step(10);

        // 5. Button held across grant and lockout.
        btn_raw = 1'b1;
        step(6);
        chk("held_request", {7'd0, ped_button}, 8'd1);
        ped_walk = 1'b1;
        step(1);
        chk("held_grant_total", req_total, 8'd3);
        ped_walk = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("held_no_rerequest", {7'd0, ped_button}, 8'd0);
        end
        chk("held_total", req_total, 8'd3);
        btn_raw = 1'b0;
        step(4);
        // Re-press with ped_walk already high; it is ignored in IDLE and DEBOUNCE.
        btn_raw  = 1'b1;
        ped_walk = 1'b1;
        step(5);
        chk("walkhigh_deb_pb", {7'd0, ped_button}, 8'd0);
        chk("walkhigh_deb_total", req_total, 8'd3);
        step(1);
        chk("walkhigh_request", {7'd0, ped_button}, 8'd1);
        chk("walkhigh_req_wc", {4'd0, walk_count}, 8'd0);
        step(1);
        chk("walkhigh_grant_pb", {7'd0, ped_button}, 8'd0);
        chk("walkhigh_grant_wc", {4'd0, walk_count}, 8'd8);
        chk("walkhigh_total", req_total, 8'd4);
        ped_walk = 1'b0;
        btn_raw  = 1'b0;
        step(12);

        // 6b. Wrap of req_total after 256 grants.
        for (int i = 0; i < 251; i++) full_cycle();
        chk("wrap_255", req_total, 8'd255);
        full_cycle();
        chk("wrap_0", req_total, 8'd0);
        chk("wrap_idle_pb", {7'd0, ped_button}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
